// File: rtl/note_lane_tracker_if.sv
// Bus between the note sequencer, key decoder, renderer and the note lane tracker.
// The master side drives spawns, hits, frame ticks and read selects; the slave responds.
interface note_lane_tracker_if #(
  parameter int unsigned KEY_W  = 3,
  parameter int unsigned X_W    = 11,
  parameter int unsigned Y_W    = 10,
  parameter int unsigned SLOT_W = 3
);
  logic              frame_tick;
  logic              spawn_valid;
  logic [KEY_W-1:0]  spawn_key;
  logic              spawn_ready;
  logic              hit_valid;
  logic [KEY_W-1:0]  hit_key;
  logic              hit_pulse;
  logic              hit_miss_pulse;
  logic [SLOT_W:0]   miss_count;
  logic [15:0]       score;
  logic [SLOT_W-1:0] rd_slot;
  logic              rd_valid;
  logic [X_W-1:0]    rd_x;
  logic [Y_W-1:0]    rd_y;

  modport master (
    output frame_tick, spawn_valid, spawn_key, hit_valid, hit_key, rd_slot,
    input  spawn_ready, hit_pulse, hit_miss_pulse, miss_count, score, rd_valid, rd_x, rd_y
  );

  modport slave (
    input  frame_tick, spawn_valid, spawn_key, hit_valid, hit_key, rd_slot,
    output spawn_ready, hit_pulse, hit_miss_pulse, miss_count, score, rd_valid, rd_x, rd_y
  );
endinterface

// File: rtl/note_lane_tracker.sv
// Falling-note tracker: maps keys to lane y, advances notes per frame, judges hits against
// the hit window, retires passed notes and keeps a saturating score.
module note_lane_tracker #(
  parameter int unsigned NUM_KEYS  = 8,
  parameter int unsigned KEY_W     = 3,
  parameter int unsigned Y_W       = 10,
  parameter int unsigned Y_BASE    = 485,
  parameter int unsigned Y_STEP    = 25,
  parameter int unsigned Y_DEFAULT = 500,
  parameter int unsigned X_W       = 11,
  parameter int unsigned X_START   = 1024,
  parameter int unsigned SPEED     = 4,
  parameter int unsigned HIT_X     = 100,
  parameter int unsigned HIT_WIN   = 16,
  parameter int unsigned SLOTS     = 8,
  parameter int unsigned SLOT_W    = 3
) (
  input logic            clk_in,
  input logic            rst_in,
  note_lane_tracker_if.slave bus
);

  function automatic logic [Y_W-1:0] lane_y(input logic [KEY_W-1:0] key);
    if (32'(key) >= NUM_KEYS) return Y_W'(Y_DEFAULT);
    return Y_W'(Y_BASE - 32'(key) * Y_STEP);
  endfunction

  // Distance to the hit line taken in whichever direction avoids unsigned wrap.
  function automatic logic in_window(input logic [X_W-1:0] x);
    int unsigned xv;
    xv = 32'(x);
    if (xv >= HIT_X) return (xv - HIT_X) <= HIT_WIN;
    return (HIT_X - xv) <= HIT_WIN;
  endfunction

  logic [SLOTS-1:0] active_q, active_d;
  logic [X_W-1:0]   x_q [SLOTS];
  logic [X_W-1:0]   x_d [SLOTS];
  logic [Y_W-1:0]   y_q [SLOTS];
  logic [Y_W-1:0]   y_d [SLOTS];

  logic              hit_pulse_q, hit_miss_pulse_q;
  logic [SLOT_W:0]   miss_count_q, retire_cnt;
  logic [15:0]       score_q;
  logic              rd_valid_q;
  logic [X_W-1:0]    rd_x_q;
  logic [Y_W-1:0]    rd_y_q;

  logic              free_found, win_found;
  logic [SLOT_W-1:0] free_idx, win_idx;
  logic [X_W-1:0]    win_x;
  logic [Y_W-1:0]    hit_lane, spawn_lane;
  logic              spawn_fire, hit_fire;

  assign bus.spawn_ready    = ~&active_q;
  assign bus.hit_pulse      = hit_pulse_q;
  assign bus.hit_miss_pulse = hit_miss_pulse_q;
  assign bus.miss_count     = miss_count_q;
  assign bus.score          = score_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_x           = rd_x_q;
  assign bus.rd_y           = rd_y_q;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!active_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  // Strict less-than while scanning upward keeps the lowest index on equal x.
  always_comb begin
    hit_lane  = lane_y(bus.hit_key);
    win_found = 1'b0;
    win_idx   = '0;
    win_x     = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (active_q[i] && (y_q[i] == hit_lane) && in_window(x_q[i]) &&
          (!win_found || (x_q[i] < win_x))) begin
        win_found = 1'b1;
        win_idx   = SLOT_W'(i);
        win_x     = x_q[i];
      end
    end
  end

  always_comb begin
    spawn_lane = lane_y(bus.spawn_key);
    spawn_fire = bus.spawn_valid & bus.spawn_ready;
    hit_fire   = bus.hit_valid & win_found;
    active_d   = active_q;
    x_d        = x_q;
    y_d        = y_q;
    retire_cnt = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (hit_fire && (win_idx == SLOT_W'(i))) begin
        active_d[i] = 1'b0;
        x_d[i]      = '0;
        y_d[i]      = '0;
      end else if (bus.frame_tick && active_q[i]) begin
        if (32'(x_q[i]) >= SPEED) begin
          x_d[i] = x_q[i] - X_W'(SPEED);
        end else begin
          active_d[i] = 1'b0;
          x_d[i]      = '0;
          y_d[i]      = '0;
          retire_cnt  = retire_cnt + {{SLOT_W{1'b0}}, 1'b1};
        end
      end
    end
    // The free slot comes from registered state, so it was inactive and is never ticked.
    if (spawn_fire) begin
      active_d[free_idx] = 1'b1;
      x_d[free_idx]      = X_W'(X_START);
      y_d[free_idx]      = spawn_lane;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      active_q <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      hit_pulse_q      <= 1'b0;
      hit_miss_pulse_q <= 1'b0;
      miss_count_q     <= '0;
      score_q          <= '0;
      rd_valid_q       <= 1'b0;
      rd_x_q           <= '0;
      rd_y_q           <= '0;
    end else begin
      active_q         <= active_d;
      x_q              <= x_d;
      y_q              <= y_d;
      hit_pulse_q      <= hit_fire;
      hit_miss_pulse_q <= bus.hit_valid & ~win_found;
      miss_count_q     <= retire_cnt;
      if (hit_fire && (score_q != 16'hFFFF)) score_q <= score_q + 16'd1;
      rd_valid_q       <= active_q[bus.rd_slot];
      rd_x_q           <= active_q[bus.rd_slot] ? x_q[bus.rd_slot] : '0;
      rd_y_q           <= active_q[bus.rd_slot] ? y_q[bus.rd_slot] : '0;
    end
  end

endmodule

// File: tb/tb_note_lane_tracker.sv
// Scoreboard bench for note_lane_tracker: stimulus pushes expected responses, a monitor
// pops and compares them whenever the DUT presents a read result, pulse or miss count.
module tb_note_lane_tracker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  note_lane_tracker_if bus  ();
  note_lane_tracker_if bus6 ();

  note_lane_tracker dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  note_lane_tracker #(.NUM_KEYS(6)) dut6 (.clk_in(clk), .rst_in(rst), .bus(bus6));

  typedef struct packed {logic v; logic [10:0] x; logic [9:0] y;} rd_t;
  typedef struct packed {logic is_hit; logic [15:0] score;} ev_t;

  rd_t rd_q [$];
  ev_t ev_q [$];
  int  miss_q [$];

  int total = 0;
  int bad   = 0;

  logic rd_req   = 1'b0;
  logic rd_req_d = 1'b0;
  always @(posedge clk) rd_req_d <= rd_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lane(input int k, input int nk);
    return (k >= nk) ? 500 : 485 - 25 * k;
  endfunction

  rd_t re;
  ev_t ee;
  int  me;
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_req_d) begin
        chk("rd_q_nonempty", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) begin
          re = rd_q.pop_front();
          chk("rd_valid", bus.rd_valid, re.v);
          chk("rd_x", bus.rd_x, re.x);
          chk("rd_y", bus.rd_y, re.y);
        end
      end
      if (bus.hit_pulse || bus.hit_miss_pulse) begin
        chk("ev_q_nonempty", ev_q.size() > 0, 1);
        if (ev_q.size() > 0) begin
          ee = ev_q.pop_front();
          chk("hit_pulse", bus.hit_pulse, ee.is_hit);
          chk("hit_miss_pulse", bus.hit_miss_pulse, !ee.is_hit);
          chk("score", bus.score, ee.score);
        end
      end
      if (bus.miss_count != 0) begin
        chk("miss_q_nonempty", miss_q.size() > 0, 1);
        if (miss_q.size() > 0) begin
          me = miss_q.pop_front();
          chk("miss_count", bus.miss_count, me);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_spawn(input logic [2:0] k);
    bus.spawn_valid = 1'b1;
    bus.spawn_key   = k;
    cyc();
    bus.spawn_valid = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] s, input logic v, input int x, input int y);
    rd_t e;
    e.v = v;
    e.x = 11'(x);
    e.y = 10'(y);
    rd_q.push_back(e);
    bus.rd_slot = s;
    rd_req      = 1'b1;
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic do_hit(input logic [2:0] k, input logic is_hit, input int sc);
    ev_t e;
    e.is_hit = is_hit;
    e.score  = 16'(sc);
    ev_q.push_back(e);
    bus.hit_valid = 1'b1;
    bus.hit_key   = k;
    cyc();
    bus.hit_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d want 0 remaining", 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_tick = 0; bus.spawn_valid = 0; bus.spawn_key = 0;
    bus.hit_valid = 0; bus.hit_key = 0; bus.rd_slot = 0;
    bus6.frame_tick = 0; bus6.spawn_valid = 0; bus6.spawn_key = 0;
    bus6.hit_valid = 0; bus6.hit_key = 0; bus6.rd_slot = 0;

    #2 rst = 1'b1;
    #1;
    chk("rst_spawn_ready", bus.spawn_ready, 1);
    chk("rst_hit_pulse", bus.hit_pulse, 0);
    chk("rst_hit_miss", bus.hit_miss_pulse, 0);
    chk("rst_miss_count", bus.miss_count, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Lane mapping and full condition
    for (int k = 0; k < 8; k++) do_spawn(3'(k));
    chk("full_spawn_ready", bus.spawn_ready, 0);
    for (int s = 0; s < 8; s++) do_read(3'(s), 1'b1, 1024, lane(s, 8));
    do_spawn(3'd3);
    chk("drop_spawn_ready", bus.spawn_ready, 0);

    // Window boundaries: 120 is outside, 116 is inside
    ticks(226);
    do_hit(3'd0, 1'b0, 0);
    chk("miss_keeps_full", bus.spawn_ready, 0);
    ticks(1);
    do_hit(3'd1, 1'b1, 1);
    chk("hit_frees_slot", bus.spawn_ready, 1);
    do_spawn(3'd6);
    chk("refill_spawn_ready", bus.spawn_ready, 0);
    do_read(3'd1, 1'b1, 1024, 335);

    ticks(2);
    do_hit(3'd2, 1'b1, 2);
    do_hit(3'd2, 1'b0, 2);
    do_spawn(3'd4);

    // Hit, tick and spawn in one cycle with all slots full
    ee.is_hit = 1'b1;
    ee.score  = 16'd3;
    ev_q.push_back(ee);
    bus.hit_valid = 1'b1; bus.hit_key = 3'd3;
    bus.frame_tick = 1'b1;
    bus.spawn_valid = 1'b1; bus.spawn_key = 3'd0;
    cyc();
    bus.hit_valid = 1'b0; bus.frame_tick = 1'b0; bus.spawn_valid = 1'b0;
    chk("simul_spawn_ready", bus.spawn_ready, 1);
    do_read(3'd0, 1'b1, 104, 485);
    do_read(3'd1, 1'b1, 1012, 335);
    do_read(3'd2, 1'b1, 1020, 385);
    do_read(3'd3, 1'b0, 0, 0);
    do_read(3'd7, 1'b1, 104, 310);

    // Same lane in slots 2 and 4; only slot 4 is in the window
    do_hit(3'd4, 1'b1, 4);
    do_read(3'd2, 1'b1, 1020, 385);
    do_read(3'd4, 1'b0, 0, 0);
    do_read(3'd0, 1'b1, 104, 485);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_score", bus.score, 0);
    chk("midrst_spawn_ready", bus.spawn_ready, 1);
    chk("midrst_rd_valid", bus.rd_valid, 0);
    chk("midrst_rd_x", bus.rd_x, 0);
    chk("midrst_hit_pulse", bus.hit_pulse, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    do_read(3'd0, 1'b0, 0, 0);

    // Retirement
    do_spawn(3'd0);
    do_spawn(3'd1);
    ticks(256);
    do_read(3'd0, 1'b1, 0, 485);
    do_read(3'd1, 1'b1, 0, 460);
    miss_q.push_back(2);
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    do_read(3'd0, 1'b0, 0, 0);
    do_read(3'd1, 1'b0, 0, 0);
    chk("retire_spawn_ready", bus.spawn_ready, 1);

    // Out-of-range keys with NUM_KEYS=6
    bus6.spawn_valid = 1'b1; bus6.spawn_key = 3'd7;
    cyc();
    bus6.spawn_key = 3'd5;
    cyc();
    bus6.spawn_key = 3'd6;
    cyc();
    bus6.spawn_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      bus6.rd_slot = 3'(s);
      cyc();
      chk("k6_rd_valid", bus6.rd_valid, 1);
      chk("k6_rd_y", bus6.rd_y, lane((s == 0) ? 7 : (s == 1) ? 5 : 6, 6));
    end

    repeat (3) cyc();
    chk("rd_q_drained", rd_q.size(), 0);
    chk("ev_q_drained", ev_q.size(), 0);
    chk("miss_q_drained", miss_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
